// File: rtl/sed_scrub_ctrl.sv
// sed_scrub_ctrl: sequences SEDGA CRC scrub passes (one-shot or periodic),
// guards each pass with a watchdog and accumulates error status.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | sed_enable low, waiting for run_once or auto_mode
// ARM   | sed_enable high, letting SEDGA wake for WAKE_CYCLES
// START | sed_start high until SEDGA reports sed_inprog
// RUN   | scrub in progress, waiting for sed_done
// CHECK | one cycle: sample sed_err, update counters
// GAP   | sed_enable low for PERIOD cycles between auto-mode passes
module sed_scrub_ctrl #(
  parameter int PERIOD      = 4096,
  parameter int WAKE_CYCLES = 4,
  parameter int TIMEOUT     = 2097152,
  parameter int CNT_W       = 8
) (
  input  logic             clkout,
  input  logic             reset,
  input  logic             en,
  input  logic             auto_mode,
  input  logic             run_once,
  input  logic             frc_err_req,
  input  logic             err_clr,
  input  logic             sed_done,
  input  logic             sed_inprog,
  input  logic             sed_err,
  output logic             sed_enable,
  output logic             sed_start,
  output logic             sed_frcerr,
  output logic             busy,
  output logic             err_flag,
  output logic             timeout_flag,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] pass_count
);

  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam int GAP_W  = $clog2(PERIOD + 1);
  localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);

  localparam logic [WD_W-1:0]   WD_LOAD   = WD_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(PERIOD - 1);
  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_CHECK = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t             state;
  logic [WD_W-1:0]    wd_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [WAKE_W-1:0]  wake_cnt;
  logic               frc_pend;

  logic               wd_expired;
  logic               check_evt;
  logic               timeout_evt;
  logic               err_inc;
  logic [CNT_W-1:0]   err_base;
  logic [CNT_W-1:0]   pass_base;
  logic [CNT_W-1:0]   err_count_nxt;
  logic [CNT_W-1:0]   pass_count_nxt;

  // Pass-end events feeding the status registers; done beats a same-cycle watchdog expiry.
  always_comb begin
    wd_expired  = 1'b0;
    check_evt   = 1'b0;
    timeout_evt = 1'b0;
    if (en) begin
      wd_expired  = (wd_cnt == '0);
      check_evt   = (state == S_CHECK);
      timeout_evt = wd_expired &&
                    ((state == S_START) || ((state == S_RUN) && !sed_done));
    end
  end

  // Next counter values: a same-cycle event wins over err_clr.
  always_comb begin
    err_base       = err_clr ? '0 : err_count;
    pass_base      = err_clr ? '0 : pass_count;
    err_inc        = (check_evt && sed_err) || timeout_evt;
    err_count_nxt  = err_base;
    pass_count_nxt = pass_base;
    if (err_inc && (err_base != '1))
      err_count_nxt = err_base + CNT_W'(1);
    if (check_evt)
      pass_count_nxt = pass_base + CNT_W'(1);
  end

  // Sticky flags and counters for the host register file.
  always_ff @(posedge clkout or posedge reset) begin
    if (reset) begin
      err_flag     <= 1'b0;
      timeout_flag <= 1'b0;
      err_count    <= '0;
      pass_count   <= '0;
    end else begin
      err_flag     <= (check_evt && sed_err) || (err_flag && !err_clr);
      timeout_flag <= timeout_evt || (timeout_flag && !err_clr);
      err_count    <= err_count_nxt;
      pass_count   <= pass_count_nxt;
    end
  end

  // Sequencing FSM with registered SEDGA controls, timers and forced-error latch.
  always_ff @(posedge clkout or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      sed_enable <= 1'b0;
      sed_start  <= 1'b0;
      sed_frcerr <= 1'b0;
      busy       <= 1'b0;
      wd_cnt     <= '0;
      gap_cnt    <= '0;
      wake_cnt   <= '0;
      frc_pend   <= 1'b0;
    end else begin
      sed_frcerr <= 1'b0;
      frc_pend   <= frc_pend || frc_err_req;
      if (!en) begin
        state      <= S_IDLE;
        sed_enable <= 1'b0;
        sed_start  <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (run_once || auto_mode) begin
              state      <= S_ARM;
              sed_enable <= 1'b1;
              busy       <= 1'b1;
              wake_cnt   <= WAKE_LOAD;
            end
          end
          S_ARM: begin
            if (wake_cnt == '0) begin
              state     <= S_START;
              sed_start <= 1'b1;
              wd_cnt    <= WD_LOAD;
            end else begin
              wake_cnt <= wake_cnt - WAKE_W'(1);
            end
          end
          S_START: begin
            if (wd_expired) begin
              sed_start  <= 1'b0;
              sed_enable <= 1'b0;
              busy       <= 1'b0;
              gap_cnt    <= GAP_LOAD;
              state      <= auto_mode ? S_GAP : S_IDLE;
            end else begin
              wd_cnt <= wd_cnt - WD_W'(1);
              if (sed_inprog) begin
                state      <= S_RUN;
                sed_start  <= 1'b0;
                // Pending force is spent on this pass; a same-cycle request waits for the next.
                sed_frcerr <= frc_pend;
                frc_pend   <= frc_err_req;
              end
            end
          end
          S_RUN: begin
            if (sed_done) begin
              state <= S_CHECK;
            end else if (wd_expired) begin
              sed_enable <= 1'b0;
              busy       <= 1'b0;
              gap_cnt    <= GAP_LOAD;
              state      <= auto_mode ? S_GAP : S_IDLE;
            end else begin
              wd_cnt <= wd_cnt - WD_W'(1);
            end
          end
          S_CHECK: begin
            // Dropping sed_enable here clears SEDDONE/SEDERR before the next pass.
            sed_enable <= 1'b0;
            busy       <= 1'b0;
            gap_cnt    <= GAP_LOAD;
            state      <= auto_mode ? S_GAP : S_IDLE;
          end
          S_GAP: begin
            if (!auto_mode) begin
              state <= S_IDLE;
            end else if (gap_cnt == '0) begin
              state      <= S_ARM;
              sed_enable <= 1'b1;
              busy       <= 1'b1;
              wake_cnt   <= WAKE_LOAD;
            end else begin
              gap_cnt <= gap_cnt - GAP_W'(1);
            end
          end
          default: begin
            state      <= S_IDLE;
            sed_enable <= 1'b0;
            sed_start  <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sed_scrub_ctrl.sv
// tb_sed_scrub_ctrl: directed bench for sed_scrub_ctrl with a behavioural SEDGA stub.
module tb_sed_scrub_ctrl;

  localparam int PASS_LEN = 20;

  logic       clkout = 1'b0;
  logic       reset;
  logic       en, auto_mode, run_once, frc_err_req, err_clr;
  logic       sed_done, sed_inprog, sed_err;
  logic       sed_enable, sed_start, sed_frcerr, busy, err_flag, timeout_flag;
  logic [1:0] err_count, pass_count;

  logic       hang;
  logic       frc_seen;
  int         stub_cnt;

  int         checks = 0;
  int         errors = 0;
  int         n;

  sed_scrub_ctrl #(
    .PERIOD(8), .WAKE_CYCLES(2), .TIMEOUT(64), .CNT_W(2)
  ) dut (
    .clkout(clkout), .reset(reset), .en(en), .auto_mode(auto_mode),
    .run_once(run_once), .frc_err_req(frc_err_req), .err_clr(err_clr),
    .sed_done(sed_done), .sed_inprog(sed_inprog), .sed_err(sed_err),
    .sed_enable(sed_enable), .sed_start(sed_start), .sed_frcerr(sed_frcerr),
    .busy(busy), .err_flag(err_flag), .timeout_flag(timeout_flag),
    .err_count(err_count), .pass_count(pass_count)
  );

  always #5 clkout = ~clkout;

  // SEDGA stub: pass of PASS_LEN cycles, error if a force was seen, never finishes when hang.
  always @(posedge clkout or posedge reset) begin
    if (reset) begin
      sed_inprog <= 1'b0; sed_done <= 1'b0; sed_err <= 1'b0;
      frc_seen <= 1'b0; stub_cnt <= 0;
    end else if (!sed_enable) begin
      sed_inprog <= 1'b0; sed_done <= 1'b0; sed_err <= 1'b0;
      frc_seen <= 1'b0; stub_cnt <= 0;
    end else if (sed_inprog) begin
      if (sed_frcerr) frc_seen <= 1'b1;
      if (!hang) begin
        if (stub_cnt == 1) begin
          sed_inprog <= 1'b0;
          sed_done   <= 1'b1;
          sed_err    <= frc_seen | sed_frcerr;
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end else if (sed_start && !sed_done) begin
      sed_inprog <= 1'b1;
      stub_cnt   <= PASS_LEN;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig_sel(input int which);
    case (which)
      0: return sed_enable;
      1: return sed_start;
      2: return sed_frcerr;
      3: return busy;
      4: return timeout_flag;
      default: return sed_done;
    endcase
  endfunction

  // Counts negedges until the selected signal equals val; an expired bound is a failure.
  task automatic wait_for(input string tag, input int which, input logic val,
                          input int max, output int cnt);
    cnt = 0;
    while (sig_sel(which) !== val && cnt < max) begin
      @(negedge clkout);
      cnt++;
    end
    if (sig_sel(which) !== val) begin
      checks++;
      errors++;
      $error("FAIL %s: wait expired after %0d cycles, required level %0d", tag, cnt, val);
    end
  endtask

  task automatic pulse_run();
    run_once = 1'b1; @(negedge clkout); run_once = 1'b0;
  endtask

  task automatic pulse_frc();
    frc_err_req = 1'b1; @(negedge clkout); frc_err_req = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; @(negedge clkout); err_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; auto_mode = 1'b0; run_once = 1'b0;
    frc_err_req = 1'b0; err_clr = 1'b0; hang = 1'b0;
    repeat (3) @(negedge clkout);
    check("rst_enable", sed_enable, 0);
    check("rst_start", sed_start, 0);
    check("rst_busy", busy, 0);
    check("rst_err_count", err_count, 0);
    check("rst_pass_count", pass_count, 0);
    reset = 1'b0;
    en = 1'b1;
    @(negedge clkout);

    // 1: single pass
    pulse_run();
    wait_for("t1_en_rise", 0, 1'b1, 10, n);
    wait_for("t1_start_rise", 1, 1'b1, 10, n);
    check("t1_wake_delay", n, 2);
    wait_for("t1_done", 3, 1'b0, 200, n);
    check("t1_pass_count", pass_count, 1);
    check("t1_err_flag", err_flag, 0);
    check("t1_enable_low", sed_enable, 0);
    check("t1_timeout_flag", timeout_flag, 0);

    // 2: forced error
    pulse_frc();
    pulse_run();
    wait_for("t2_start_rise", 1, 1'b1, 10, n);
    wait_for("t2_frc_rise", 2, 1'b1, 10, n);
    check("t2_frc_delay", n, 2);
    check("t2_frc_in_run", sed_start, 0);
    @(negedge clkout);
    check("t2_frc_one_cycle", sed_frcerr, 0);
    wait_for("t2_done", 3, 1'b0, 200, n);
    check("t2_err_flag", err_flag, 1);
    check("t2_err_count", err_count, 1);
    check("t2_pass_count", pass_count, 2);

    // 3: auto mode, three passes
    pulse_clr();
    check("t3_clr_err_flag", err_flag, 0);
    check("t3_clr_pass_count", pass_count, 0);
    auto_mode = 1'b1;
    wait_for("t3_p1_rise", 0, 1'b1, 10, n);
    wait_for("t3_p1_fall", 0, 1'b0, 200, n);
    wait_for("t3_gap1", 0, 1'b1, 50, n);
    check("t3_gap1_len", n, 8);
    wait_for("t3_p2_fall", 0, 1'b0, 200, n);
    wait_for("t3_gap2", 0, 1'b1, 50, n);
    check("t3_gap2_len", n, 8);
    wait_for("t3_p3_fall", 0, 1'b0, 200, n);
    auto_mode = 1'b0;
    repeat (12) @(negedge clkout);
    check("t3_pass_count", pass_count, 3);
    check("t3_stays_idle", sed_enable, 0);
    check("t3_busy", busy, 0);
    check("t3_err_count", err_count, 0);

    // 4: watchdog
    pulse_clr();
    hang = 1'b1;
    pulse_run();
    wait_for("t4_start_rise", 1, 1'b1, 10, n);
    wait_for("t4_timeout", 4, 1'b1, 200, n);
    check("t4_timeout_delay", n, 64);
    check("t4_err_count", err_count, 1);
    check("t4_pass_count", pass_count, 0);
    check("t4_enable_low", sed_enable, 0);
    check("t4_busy", busy, 0);
    hang = 1'b0;
    repeat (2) @(negedge clkout);

    // 5a: abort mid-RUN
    pulse_clr();
    check("t5_clr_timeout", timeout_flag, 0);
    pulse_run();
    wait_for("t5_start_rise", 1, 1'b1, 10, n);
    wait_for("t5_start_fall", 1, 1'b0, 10, n);
    repeat (3) @(negedge clkout);
    en = 1'b0;
    @(negedge clkout);
    check("t5_abort_enable", sed_enable, 0);
    check("t5_abort_busy", busy, 0);
    en = 1'b1;
    repeat (4) @(negedge clkout);
    check("t5_abort_idle", busy, 0);
    check("t5_abort_pass_count", pass_count, 0);

    // 5b: err_clr coinciding with a CHECK error
    pulse_frc();
    pulse_run();
    wait_for("t5b_p1", 3, 1'b0, 200, n);
    check("t5b_pre_err_count", err_count, 1);
    pulse_frc();
    pulse_run();
    wait_for("t5b_done", 5, 1'b1, 200, n);
    @(negedge clkout);
    pulse_clr();
    check("t5b_err_flag", err_flag, 1);
    check("t5b_err_count", err_count, 1);
    check("t5b_pass_count", pass_count, 1);

    // 6: saturation and wrap with 2-bit counters
    pulse_clr();
    for (int i = 0; i < 5; i++) begin
      pulse_frc();
      pulse_run();
      wait_for("t6_pass", 3, 1'b0, 200, n);
    end
    check("t6_err_count_sat", err_count, 3);
    check("t6_pass_count_wrap", pass_count, 1);
    check("t6_err_flag", err_flag, 1);

    // Async reset mid-pass drops controls without a clock edge
    pulse_run();
    wait_for("t7_start_rise", 1, 1'b1, 10, n);
    #2 reset = 1'b1;
    #1;
    check("t7_rst_enable", sed_enable, 0);
    check("t7_rst_start", sed_start, 0);
    check("t7_rst_err_count", err_count, 0);
    @(negedge clkout);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
